truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner_pkg.sv | 13 +
 rtl/decoder38_logFun.sv | 19 +
 rtl/truth_table_scanner.sv | 85 ++++++++
 tb/tb_truth_table_scanner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth table scanner.
// State encoding and minterm count used by the scanner.
package truth_table_scanner_pkg;

   localparam int MINTERMS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/decoder38_logFun.sv
// Logic function under test: a 3-to-8 decoder whose minterm
// outputs 1, 3, 6 and 7 are ORed, giving Fun = ~A&C | A&B.
module decoder38_logFun (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic Fun
);

   logic [7:0] y;

   // one-hot decode of {A,B,C}, then OR the selected minterms
   always_comb begin
      y = 8'h00;
      y[{A, B, C}] = 1'b1;
      Fun = y[1] | y[3] | y[6] | y[7];
   end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks {A,B,C} through all eight minterms, lets the function
// settle, and captures its response into an 8-bit truth table.
module truth_table_scanner
   import truth_table_scanner_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       A,
   output logic       B,
   output logic       C,
   input  logic       Fun,
   output logic       busy,
   output logic       done,
   output logic [7:0] truth_table,
   output logic [3:0] ones_cnt
);

   localparam logic [3:0] LAST_WAIT = 4'(SETTLE_CYCLES - 1);
   localparam logic [2:0] LAST_IDX  = 3'(MINTERMS - 1);

   state_t     state;
   logic [2:0] idx;
   logic [3:0] wt;

   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
      return n;
   endfunction

   // scan sequencer: drive minterm, wait, capture, advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= 3'd0;
         wt          <= 4'd0;
         {A, B, C}   <= 3'b000;
         busy        <= 1'b0;
         done        <= 1'b0;
         truth_table <= 8'h00;
         ones_cnt    <= 4'd0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  truth_table <= 8'h00;
                  idx         <= 3'd0;
                  wt          <= 4'd0;
                  {A, B, C}   <= 3'b000;
                  busy        <= 1'b1;
                  state       <= DRIVE;
               end
            end
            DRIVE: begin
               if (wt == LAST_WAIT) begin
                  truth_table[idx] <= Fun;
                  wt               <= 4'd0;
                  if (idx != LAST_IDX) begin
                     idx       <= idx + 3'd1;
                     {A, B, C} <= idx + 3'd1;
                  end else begin
                     {A, B, C} <= 3'b000;
                     busy      <= 1'b0;
                     state     <= DONE;
                  end
               end else begin
                  wt <= wt + 4'd1;
               end
            end
            DONE: begin
               done     <= 1'b1;
               ones_cnt <= popcount(truth_table);
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: two scanners (settle 1 and 3) driving the
// decoder-based function, with directed scans and reset abort.
module tb_truth_table_scanner;

   typedef struct {
      logic [7:0] tbl;
      logic [3:0] ones;
      int         done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start1 = 1'b0;
   logic start3 = 1'b0;
   int   sel1 = 0;
   int   sel3 = 0;
   int   cyc = 0;
   int   c0_1 = 0;
   int   c0_3 = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   exp_t sb1[$];
   exp_t sb3[$];

   logic a1, b1, c1, f1, d1fun, busy1, done1;
   logic a3, b3, c3, f3, d3fun, busy3, done3;
   logic [7:0] tt1, tt3;
   logic [3:0] on1, on3;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   decoder38_logFun u_fn1 (.A(a1), .B(b1), .C(c1), .Fun(d1fun));
   decoder38_logFun u_fn3 (.A(a3), .B(b3), .C(c3), .Fun(d3fun));

   assign f1 = (sel1 == 0) ? d1fun : (sel1 == 2);
   assign f3 = (sel3 == 0) ? d3fun : (sel3 == 2);

   truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .A(a1), .B(b1), .C(c1), .Fun(f1),
      .busy(busy1), .done(done1),
      .truth_table(tt1), .ones_cnt(on1)
   );

   truth_table_scanner #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3),
      .A(a3), .B(b3), .C(c3), .Fun(f3),
      .busy(busy3), .done(done3),
      .truth_table(tt3), .ones_cnt(on3)
   );

   task automatic check(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // monitor for settle=1: minterm order while busy, results on done
   always @(negedge clk) begin
      if (busy1)
         check("abc1_seq", {a1, b1, c1}, (cyc - c0_1) % 8);
      if (done1) begin
         if (sb1.size() == 0) begin
            check("done1_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = sb1.pop_front();
            check("done1_cyc", cyc, e.done_cyc);
            check("table1", tt1, e.tbl);
            check("ones1", on1, e.ones);
         end
      end
   end

   // monitor for settle=3
   always @(negedge clk) begin
      if (busy3)
         check("abc3_seq", {a3, b3, c3}, ((cyc - c0_3) / 3) % 8);
      if (done3) begin
         if (sb3.size() == 0) begin
            check("done3_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = sb3.pop_front();
            check("done3_cyc", cyc, e.done_cyc);
            check("table3", tt3, e.tbl);
            check("ones3", on3, e.ones);
         end
      end
   end

   task automatic scan(input int which, input logic [7:0] tbl,
                       input logic [3:0] ones);
      exp_t e;
      @(negedge clk);
      if (which == 1) start1 = 1'b1;
      else start3 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start3 = 1'b0;
      e.tbl  = tbl;
      e.ones = ones;
      if (which == 1) begin
         c0_1 = cyc;
         e.done_cyc = cyc + 9;
         sb1.push_back(e);
      end else begin
         c0_3 = cyc;
         e.done_cyc = cyc + 25;
         sb3.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb1.size() != 0 || sb3.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         check("drain_timeout", n, 0);
         sb1.delete();
         sb3.delete();
      end
   endtask

   initial begin
      #2;
      check("rst_busy1", busy1, 0);
      check("rst_done1", done1, 0);
      check("rst_abc1", {a1, b1, c1}, 0);
      check("rst_table1", tt1, 0);
      check("rst_ones1", on1, 0);
      check("rst_table3", tt3, 0);
      repeat (2) @(negedge clk);

      // release reset with start already high: first edge accepts it
      begin
         exp_t e;
         rst_n  = 1'b1;
         start1 = 1'b1;
         @(posedge clk);
         #1;
         start1 = 1'b0;
         c0_1 = cyc;
         e.tbl = 8'hCA;
         e.ones = 4'd4;
         e.done_cyc = cyc + 9;
         sb1.push_back(e);
      end
      drain();

      scan(3, 8'hCA, 4'd4);
      drain();

      sel1 = 1;
      scan(1, 8'h00, 4'd0);
      drain();
      sel1 = 2;
      scan(1, 8'hFF, 4'd8);
      drain();
      sel1 = 0;

      // repeated start during DRIVE and in the DONE cycle
      scan(3, 8'hCA, 4'd4);
      repeat (5) @(negedge clk);
      start3 = 1'b1;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      begin
         int n;
         n = 0;
         while (busy3 && n < 100) begin
            @(negedge clk);
            n++;
         end
         check("busy3_fall", busy3, 0);
      end
      start3 = 1'b1;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      drain();
      repeat (6) @(negedge clk);
      check("ignored_busy3", busy3, 0);
      check("held_table3", tt3, 8'hCA);
      check("held_ones3", on3, 4);

      // abort mid-scan at idx 4
      scan(1, 8'hCA, 4'd4);
      begin
         int n;
         n = 0;
         while (!a1 && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("reach_idx4", {a1, b1, c1}, 3'b100);
      end
      #2;
      rst_n = 1'b0;
      sb1.delete();
      #1;
      check("abort_busy", busy1, 0);
      check("abort_abc", {a1, b1, c1}, 0);
      check("abort_table", tt1, 0);
      check("abort_ones", on1, 0);
      check("abort_done", done1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_idle", busy1, 0);
      scan(1, 8'hCA, 4'd4);
      drain();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
